// File: rtl/reaction_uart_tx.sv
// rtl/reaction_uart_tx.sv - reaction time to five ASCII digits plus CR LF over a UART
// Optional even parity bit per byte when REACTION_UART_PARITY_EN is defined.
module reaction_uart_tx #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        result_valid,
  input  logic [13:0] result,
  output logic        ready,
  output logic        tx,
  output logic        overrun
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CONVERT,
    S_START,
    S_DATA,
`ifdef REACTION_UART_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

  state_t      state_q, state_d;
  logic [15:0] baud_q, baud_d;
  logic [3:0]  conv_cnt_q, conv_cnt_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [2:0]  byte_idx_q, byte_idx_d;
  logic [33:0] shreg_q, shreg_d;
  logic        tx_q, tx_d;
  logic        ready_q, ready_d;
  logic        overrun_q, overrun_d;

  logic        baud_end;
  logic [19:0] bcd;
  logic [7:0]  cur_byte;
  logic [33:0] adjusted;

  function automatic logic [19:0] dabble_adjust(input logic [19:0] b);
    logic [19:0] r;
    r = b;
    for (int i = 0; i < 5; i++) begin
      if (r[i*4 +: 4] >= 4'd5) r[i*4 +: 4] = r[i*4 +: 4] + 4'd3;
    end
    return r;
  endfunction

  // After conversion the upper 20 bits of the shift register hold the BCD digits.
  assign bcd      = shreg_q[33:14];
  assign baud_end = (baud_q == BAUD_LAST);
  assign adjusted = {dabble_adjust(shreg_q[33:14]), shreg_q[13:0]};

  always_comb begin
    case (byte_idx_q)
      3'd0:    cur_byte = {4'h3, bcd[19:16]};
      3'd1:    cur_byte = {4'h3, bcd[15:12]};
      3'd2:    cur_byte = {4'h3, bcd[11:8]};
      3'd3:    cur_byte = {4'h3, bcd[7:4]};
      3'd4:    cur_byte = {4'h3, bcd[3:0]};
      3'd5:    cur_byte = 8'h0D;
      default: cur_byte = 8'h0A;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    baud_d     = baud_q;
    conv_cnt_d = conv_cnt_q;
    bit_idx_d  = bit_idx_q;
    byte_idx_d = byte_idx_q;
    shreg_d    = shreg_q;
    tx_d       = tx_q;
    ready_d    = ready_q;
    overrun_d  = overrun_q | (result_valid & ~ready_q);

    if (state_q != S_IDLE && state_q != S_CONVERT) begin
      baud_d = baud_end ? 16'd0 : baud_q + 16'd1;
    end

    case (state_q)
      S_IDLE: begin
        if (result_valid) begin
          shreg_d    = {20'd0, result};
          conv_cnt_d = 4'd0;
          ready_d    = 1'b0;
          state_d    = S_CONVERT;
        end
      end
      S_CONVERT: begin
        if (conv_cnt_q == 4'd14) begin
          state_d    = S_START;
          baud_d     = 16'd0;
          byte_idx_d = 3'd0;
          tx_d       = 1'b0;
        end else begin
          shreg_d    = {adjusted[32:0], 1'b0};
          conv_cnt_d = conv_cnt_q + 4'd1;
        end
      end
      S_START: begin
        if (baud_end) begin
          state_d   = S_DATA;
          bit_idx_d = 3'd0;
          tx_d      = cur_byte[0];
        end
      end
      S_DATA: begin
        if (baud_end) begin
          if (bit_idx_q == 3'd7) begin
`ifdef REACTION_UART_PARITY_EN
            state_d = S_PARITY;
            tx_d    = ^cur_byte;
`else
            state_d = S_STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            tx_d      = cur_byte[bit_idx_d];
          end
        end
      end
`ifdef REACTION_UART_PARITY_EN
      S_PARITY: begin
        if (baud_end) begin
          state_d = S_STOP;
          tx_d    = 1'b1;
        end
      end
`endif
      S_STOP: begin
        if (baud_end) begin
          if (byte_idx_q != 3'd6) begin
            byte_idx_d = byte_idx_q + 3'd1;
            state_d    = S_START;
            tx_d       = 1'b0;
          end else begin
            state_d = S_IDLE;
            ready_d = 1'b1;
            tx_d    = 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        ready_d = 1'b1;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      baud_q     <= 16'd0;
      conv_cnt_q <= 4'd0;
      bit_idx_q  <= 3'd0;
      byte_idx_q <= 3'd0;
      shreg_q    <= 34'd0;
      tx_q       <= 1'b1;
      ready_q    <= 1'b1;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      conv_cnt_q <= conv_cnt_d;
      bit_idx_q  <= bit_idx_d;
      byte_idx_q <= byte_idx_d;
      shreg_q    <= shreg_d;
      tx_q       <= tx_d;
      ready_q    <= ready_d;
      overrun_q  <= overrun_d;
    end
  end

  assign ready   = ready_q;
  assign tx      = tx_q;
  assign overrun = overrun_q;

endmodule
